matmul_tile_scheduler: RTL and testbench
========================================

// Module: matmul_tile_scheduler
// PURPOSE
//  Sequences the 16x16 systolic matrix unit over Y[MxK] = A[MxN] * B[NxK] for M, K larger than one tile.
//  Accepts one matrix-cal command and walks output tiles row-major: mi outer, kj inner, step TILE.
//  Per tile: drives tile sizes and A/B/Y base byte addresses, pulses tile_start, waits for tile_done.
//  Reports cal_ok for the accelerator's pc_stall release.
// PARAMETERS
//  TILE        16  tile edge in elements; N must be <= TILE
//  AW          64  address width
//  ELEM_BYTES  4   bytes per element (int32)
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   reset, synchronous, active-low
//  cmd_valid   in   1   command request, level; sampled only in IDLE
//  cmd_ready   out  1   high only in IDLE
//  m_dim       in   32  A height (M)
//  n_dim       in   32  A width = B height (N)
//  k_dim       in   32  B width (K)
//  a_base      in   AW  A byte base address, row stride N*ELEM_BYTES
//  b_base      in   AW  B byte base address, row stride K*ELEM_BYTES
//  y_base      in   AW  Y byte base address, row stride K*ELEM_BYTES
//  tile_start  out  1   one-cycle pulse: launch current tile
//  tile_done   in   1   array finished current tile; ignored outside WAIT
//  tile_m      out  32  rows in tile = min(TILE, M-mi)
//  tile_k      out  32  cols in tile = min(TILE, K-kj)
//  tile_a_base out  AW  a_base + mi*N*ELEM_BYTES
//  tile_b_base out  AW  b_base + kj*ELEM_BYTES
//  tile_y_base out  AW  y_base + (mi*K+kj)*ELEM_BYTES
//  busy        out  1   high in every state except IDLE
//  cal_ok      out  1   one-cycle pulse in DONE
//  err         out  1   sticky until next accept; set when N > TILE
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except cmd_ready=1; mi, kj and latched command cleared.
//  States:
//   IDLE : cmd_valid=1 -> latch M/N/K/bases, mi=kj=0, err=0, go CHECK.
//   CHECK: M|N|K==0 -> DONE (no tiles); N>TILE -> err=1, DONE; else ISSUE.
//   ISSUE: tile_start=1 for exactly this cycle; go WAIT.
//   WAIT : hold tile_* stable; tile_done=1 -> NEXT.
//   NEXT : kj+=TILE; if kj>=K then kj=0, mi+=TILE.
//          All tiles issued -> DONE; else ISSUE.
//   DONE : cal_ok=1 for one cycle; go IDLE.
//  Timing:
//   Accept at T -> first tile_start at T+2.
//   tile_done at W -> next tile_start at W+2, or cal_ok at W+2.
//   Zero-dim/err command: cal_ok at T+2.
//  Command: inputs sampled only at accept; later changes have no effect.
//  Caller: must drop cmd_valid the cycle after cal_ok, or the command re-issues.
//  Outputs: tile_* registered, valid from ISSUE through WAIT; 0 in IDLE.
//  Arithmetic:
//   mi, kj are 32-bit; addresses are AW-bit, offsets zero-extended, wrap mod 2^AW.
//   Last partial tile: tile_m/tile_k = remainder, never 0.
//  Simultaneous events:
//   tile_done in ISSUE is ignored; the array must not assert it before seeing tile_start.
//   cmd_valid while busy is ignored and not queued.
//  Reset mid-operation: rst_n=0 in any state -> IDLE next edge.
//   tile_start and cal_ok are never asserted in that cycle; in-flight tile abandoned.
// TESTING
//  M=4,N=4,K=4, bases 0x80001000/0x80002000/0x80003000:
//   one tile_start, tile_m=tile_k=4, tile bases == command bases, cal_ok 2 cycles after tile_done.
//  M=20,N=8,K=18, same bases -> 4 tiles in order:
//   (16,16,A 0x80001000,B 0x80002000,Y 0x80003000)
//   (16,2,A 0x80001000,B 0x80002040,Y 0x80003040)
//   (4,16,A 0x80001200,B 0x80002000,Y 0x80003480)
//   (4,2,A 0x80001200,B 0x80002040,Y 0x800034C0)
//  M=0 (N=K=4) -> no tile_start, cal_ok at T+2, err=0; N=17 -> no tile_start, cal_ok at T+2, err=1.
//  tile_done held 1 during ISSUE and cmd_valid toggled while busy -> no extra tile, no second command.
//  rst_n=0 during WAIT of tile 2 of 4 -> IDLE, outputs cleared, no cal_ok.
//   New M=4 command then completes normally.

Source files
------------

// File: rtl/matmul_tile_scheduler.sv
// Output-tile sequencer for a TILE x TILE systolic array computing Y[MxK] = A[MxN] * B[NxK].
// Walks output tiles row-major, issuing one tile at a time and waiting for the array to finish it.
module matmul_tile_scheduler #(
  parameter int TILE       = 16,
  parameter int AW         = 64,
  parameter int ELEM_BYTES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [31:0]   m_dim,
  input  logic [31:0]   n_dim,
  input  logic [31:0]   k_dim,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] y_base,
  output logic          tile_start,
  input  logic          tile_done,
  output logic [31:0]   tile_m,
  output logic [31:0]   tile_k,
  output logic [AW-1:0] tile_a_base,
  output logic [AW-1:0] tile_b_base,
  output logic [AW-1:0] tile_y_base,
  output logic          busy,
  output logic          cal_ok,
  output logic          err
);

  localparam logic [31:0]   TILE_W = 32'(TILE);
  localparam logic [32:0]   TILE_X = 33'(TILE);
  localparam logic [AW-1:0] EB     = AW'(ELEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [31:0]     r_m;
  logic [31:0]     r_n;
  logic [31:0]     r_k;
  logic [AW-1:0]   r_a_base;
  logic [AW-1:0]   r_b_base;
  logic [AW-1:0]   r_y_base;
  logic [31:0]     r_mi;
  logic [31:0]     r_kj;
  logic [31:0]     r_tile_m;
  logic [31:0]     r_tile_k;
  logic [AW-1:0]   r_tile_a;
  logic [AW-1:0]   r_tile_b;
  logic [AW-1:0]   r_tile_y;
  logic            r_err;

  logic            w_zero_dim;
  logic            w_n_too_big;
  logic [32:0]     w_kj_inc;
  logic [32:0]     w_mi_inc;
  logic            w_row_wrap;
  logic            w_all_done;
  logic [31:0]     w_kj_nxt;
  logic [31:0]     w_mi_nxt;
  logic [31:0]     w_mi_sel;
  logic [31:0]     w_kj_sel;
  logic [31:0]     w_rem_m;
  logic [31:0]     w_rem_k;
  logic [31:0]     w_tile_m;
  logic [31:0]     w_tile_k;
  logic [AW-1:0]   w_a_off;
  logic [AW-1:0]   w_b_off;
  logic [AW-1:0]   w_y_off;

  assign w_zero_dim  = (r_m == 32'd0) || (r_n == 32'd0) || (r_k == 32'd0);
  assign w_n_too_big = (r_n > TILE_W);

  // 33-bit steps so a dimension near 2^32 cannot wrap the tile cursor back to zero.
  assign w_kj_inc   = {1'b0, r_kj} + TILE_X;
  assign w_mi_inc   = {1'b0, r_mi} + TILE_X;
  assign w_row_wrap = (w_kj_inc >= {1'b0, r_k});
  assign w_all_done = w_row_wrap && (w_mi_inc >= {1'b0, r_m});
  assign w_kj_nxt   = w_row_wrap ? 32'd0 : w_kj_inc[31:0];
  assign w_mi_nxt   = w_row_wrap ? w_mi_inc[31:0] : r_mi;

  // Tile geometry is computed for the tile about to be issued (first tile from CHECK, next from NEXT).
  assign w_mi_sel = (r_state == S_NEXT) ? w_mi_nxt : r_mi;
  assign w_kj_sel = (r_state == S_NEXT) ? w_kj_nxt : r_kj;
  assign w_rem_m  = r_m - w_mi_sel;
  assign w_rem_k  = r_k - w_kj_sel;
  assign w_tile_m = (w_rem_m > TILE_W) ? TILE_W : w_rem_m;
  assign w_tile_k = (w_rem_k > TILE_W) ? TILE_W : w_rem_k;

  assign w_a_off = AW'(w_mi_sel) * AW'(r_n) * EB;
  assign w_b_off = AW'(w_kj_sel) * EB;
  assign w_y_off = (AW'(w_mi_sel) * AW'(r_k) + AW'(w_kj_sel)) * EB;

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (cmd_valid) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (w_zero_dim || w_n_too_big) w_state_nxt = S_DONE;
        else                           w_state_nxt = S_ISSUE;
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (tile_done) w_state_nxt = S_NEXT;
      S_NEXT:  w_state_nxt = w_all_done ? S_DONE : S_ISSUE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_m      <= '0;
      r_n      <= '0;
      r_k      <= '0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_y_base <= '0;
      r_mi     <= '0;
      r_kj     <= '0;
      r_tile_m <= '0;
      r_tile_k <= '0;
      r_tile_a <= '0;
      r_tile_b <= '0;
      r_tile_y <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_m      <= m_dim;
            r_n      <= n_dim;
            r_k      <= k_dim;
            r_a_base <= a_base;
            r_b_base <= b_base;
            r_y_base <= y_base;
            r_mi     <= '0;
            r_kj     <= '0;
            r_err    <= 1'b0;
          end
        end
        S_CHECK: begin
          if (!w_zero_dim && w_n_too_big) r_err <= 1'b1;
        end
        S_NEXT: begin
          r_mi <= w_mi_nxt;
          r_kj <= w_kj_nxt;
        end
        S_DONE: begin
          r_tile_m <= '0;
          r_tile_k <= '0;
          r_tile_a <= '0;
          r_tile_b <= '0;
          r_tile_y <= '0;
        end
        default: ;
      endcase

      if (w_state_nxt == S_ISSUE) begin
        r_tile_m <= w_tile_m;
        r_tile_k <= w_tile_k;
        r_tile_a <= r_a_base + w_a_off;
        r_tile_b <= r_b_base + w_b_off;
        r_tile_y <= r_y_base + w_y_off;
      end
    end
  end

  // Pulses are gated by rst_n so a reset cycle never launches a tile or reports completion.
  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign tile_start  = (r_state == S_ISSUE) && rst_n;
  assign cal_ok      = (r_state == S_DONE) && rst_n;
  assign tile_m      = r_tile_m;
  assign tile_k      = r_tile_k;
  assign tile_a_base = r_tile_a;
  assign tile_b_base = r_tile_b;
  assign tile_y_base = r_tile_y;
  assign err         = r_err;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: a tile-list/timing model checks outputs every cycle,
// directed commands drive it, and literal expectations pin the model.
module tb_matmul_tile_scheduler;

  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          tile_done = 1'b0;
  logic [31:0]   m_dim = '0, n_dim = '0, k_dim = '0;
  logic [AW-1:0] a_base = '0, b_base = '0, y_base = '0;
  logic          cmd_ready, tile_start, busy, cal_ok, err;
  logic [31:0]   tile_m, tile_k;
  logic [AW-1:0] tile_a_base, tile_b_base, tile_y_base;

  matmul_tile_scheduler #(.TILE(16), .AW(AW), .ELEM_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .m_dim(m_dim), .n_dim(n_dim), .k_dim(k_dim),
    .a_base(a_base), .b_base(b_base), .y_base(y_base),
    .tile_start(tile_start), .tile_done(tile_done),
    .tile_m(tile_m), .tile_k(tile_k),
    .tile_a_base(tile_a_base), .tile_b_base(tile_b_base), .tile_y_base(tile_y_base),
    .busy(busy), .cal_ok(cal_ok), .err(err)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  int     n_starts = 0;
  int     n_cals   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    longint unsigned m, k, a, b, y;
  } tile_t;

  tile_t plan[$];

  // Expected tile list straight from the row-major walk definition.
  function automatic void build_plan(input longint unsigned mm, nn, kk, ab, bb, yb);
    plan.delete();
    for (longint unsigned mi = 0; mi < mm; mi += 16)
      for (longint unsigned kj = 0; kj < kk; kj += 16) begin
        tile_t t;
        t.m = (mm - mi > 16) ? 16 : mm - mi;
        t.k = (kk - kj > 16) ? 16 : kk - kj;
        t.a = ab + mi * nn * 4;
        t.b = bb + kj * 4;
        t.y = yb + (mi * kk + kj) * 4;
        plan.push_back(t);
      end
  endfunction

  // Model state: outstanding tiles, scheduled pulse cycles and sticky error.
  tile_t  m_q[$];
  bit     m_active  = 0;
  bit     m_in_wait = 0;
  bit     m_err     = 0;
  longint m_acc_cyc = -1, m_start_at = -1, m_cal_at = -1, m_err_at = -1;

  always @(negedge clk) begin
    bit e_start, e_cal, e_busy;
    if (cyc > 0) begin
      if (!rst_n) begin
        check("rst_tile_start", tile_start, 0);
        check("rst_cal_ok", cal_ok, 0);
        m_q.delete();
        m_active = 0; m_in_wait = 0; m_err = 0;
        m_start_at = -1; m_cal_at = -1; m_err_at = -1;
      end else begin
        if (cyc == m_err_at) m_err = 1;
        e_start = m_active && (cyc == m_start_at);
        e_cal   = m_active && (cyc == m_cal_at);
        e_busy  = m_active && (cyc > m_acc_cyc);
        check("tile_start", tile_start, e_start);
        check("cal_ok", cal_ok, e_cal);
        check("busy", busy, e_busy);
        check("cmd_ready", cmd_ready, !e_busy);
        check("err", err, m_err);
        if ((e_start || m_in_wait) && m_q.size() > 0) begin
          check("tile_m", tile_m, m_q[0].m);
          check("tile_k", tile_k, m_q[0].k);
          check("tile_a_base", tile_a_base, m_q[0].a);
          check("tile_b_base", tile_b_base, m_q[0].b);
          check("tile_y_base", tile_y_base, m_q[0].y);
        end else if (!e_busy) begin
          check("idle_tile_m", tile_m, 0);
          check("idle_tile_k", tile_k, 0);
          check("idle_tile_a", tile_a_base, 0);
          check("idle_tile_b", tile_b_base, 0);
          check("idle_tile_y", tile_y_base, 0);
        end
        if (tile_start) n_starts++;
        if (cal_ok) n_cals++;

        if (m_in_wait && tile_done) begin
          void'(m_q.pop_front());
          m_in_wait = 0;
          if (m_q.size() > 0) m_start_at = cyc + 2;
          else                m_cal_at   = cyc + 2;
        end
        if (e_start) m_in_wait = 1;
        if (!m_active && cmd_valid) begin
          bit zero, big;
          zero = (m_dim == 0) || (n_dim == 0) || (k_dim == 0);
          big  = !zero && (n_dim > 16);
          build_plan(m_dim, n_dim, k_dim, a_base, b_base, y_base);
          m_q = plan;
          m_active  = 1;
          m_acc_cyc = cyc;
          m_err     = 0;
          m_err_at  = big ? cyc + 2 : -1;
          m_start_at = (zero || big) ? -1 : cyc + 2;
          m_cal_at   = (zero || big) ? cyc + 2 : -1;
        end else if (e_cal) begin
          m_active = 0;
        end
      end
    end
  end

  longint acc_cyc, cal_cyc, done_cyc;
  logic [63:0] last_m, last_k, last_a, last_b, last_y;

  task automatic issue_cmd(input logic [31:0] mm, nn, kk);
    @(posedge clk); #1;
    m_dim = mm; n_dim = nn; k_dim = kk;
    cmd_valid = 1'b1;
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    m_dim = 32'hdead; n_dim = 32'h3; k_dim = 32'hbeef;
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (tile_start) begin
        ok = 1;
        last_m = tile_m; last_k = tile_k;
        last_a = tile_a_base; last_b = tile_b_base; last_y = tile_y_base;
      end
    end
    if (!ok) check("tile_start_timeout", 0, 1);
  endtask

  task automatic serve(input int n, input int gap);
    bit ok;
    for (int i = 0; i < n; i++) begin
      wait_start(ok);
      if (!ok) return;
      @(posedge clk);
      repeat (gap) @(posedge clk);
      #1 tile_done = 1'b1;
      done_cyc = cyc;
      @(posedge clk); #1 tile_done = 1'b0;
    end
  endtask

  task automatic wait_cal();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cal_ok) begin
        ok = 1;
        cal_cyc = cyc;
      end
    end
    if (!ok) check("cal_ok_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, c0;
    logic [63:0] exp_tab [4][5];
    exp_tab[0] = '{16, 16, 64'h80001000, 64'h80002000, 64'h80003000};
    exp_tab[1] = '{16,  2, 64'h80001000, 64'h80002040, 64'h80003040};
    exp_tab[2] = '{ 4, 16, 64'h80001200, 64'h80002000, 64'h80003480};
    exp_tab[3] = '{ 4,  2, 64'h80001200, 64'h80002040, 64'h800034C0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_tile_m", tile_m, 0);

    a_base = 64'h80001000; b_base = 64'h80002000; y_base = 64'h80003000;

    // Single small tile.
    s0 = n_starts;
    issue_cmd(4, 4, 4);
    serve(1, 2);
    wait_cal();
    check("t1_starts", n_starts - s0, 1);
    check("t1_tile_m", last_m, 4);
    check("t1_tile_k", last_k, 4);
    check("t1_a", last_a, 64'h80001000);
    check("t1_b", last_b, 64'h80002000);
    check("t1_y", last_y, 64'h80003000);
    check("t1_cal_latency", cal_cyc - done_cyc, 2);

    // Multi-tile walk; pin the model's plan against the hand table.
    build_plan(20, 8, 18, 64'h80001000, 64'h80002000, 64'h80003000);
    check("plan_size", plan.size(), 4);
    for (int i = 0; i < 4 && i < plan.size(); i++) begin
      check("plan_m", plan[i].m, exp_tab[i][0]);
      check("plan_k", plan[i].k, exp_tab[i][1]);
      check("plan_a", plan[i].a, exp_tab[i][2]);
      check("plan_b", plan[i].b, exp_tab[i][3]);
      check("plan_y", plan[i].y, exp_tab[i][4]);
    end
    s0 = n_starts;
    issue_cmd(20, 8, 18);
    serve(4, 1);
    wait_cal();
    check("t2_starts", n_starts - s0, 4);
    check("t2_last_y", last_y, 64'h800034C0);

    // Zero dimension: no tiles, immediate completion.
    s0 = n_starts;
    issue_cmd(0, 4, 4);
    wait_cal();
    check("t3_cal_latency", cal_cyc - acc_cyc, 2);
    @(negedge clk);
    check("t3_err", err, 0);
    check("t3_starts", n_starts - s0, 0);

    // N larger than a tile: error, sticky into idle.
    s0 = n_starts;
    issue_cmd(4, 17, 4);
    wait_cal();
    check("t4_cal_latency", cal_cyc - acc_cyc, 2);
    repeat (3) @(negedge clk);
    check("t4_err_sticky", err, 1);
    check("t4_starts", n_starts - s0, 0);

    // tile_done held across NEXT/ISSUE and cmd_valid pulsed while busy.
    s0 = n_starts; c0 = n_cals;
    issue_cmd(20, 8, 18);
    @(posedge clk); #1 tile_done = 1'b1;
    @(posedge clk); #1 tile_done = 1'b0;
    for (int t = 0; t < 4; t++) begin
      cmd_valid = 1'b1; m_dim = 4; n_dim = 4; k_dim = 4;
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(posedge clk); #1 tile_done = 1'b1;
      repeat (3) @(posedge clk);
      #1 tile_done = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("t5_starts", n_starts - s0, 4);
    check("t5_cals", n_cals - c0, 1);
    check("t5_idle", busy, 0);

    // Reset during the wait of tile 2 of 4.
    c0 = n_cals;
    issue_cmd(20, 8, 18);
    serve(1, 0);
    begin
      bit ok;
      wait_start(ok);
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    check("t6_tile_m", tile_m, 0);
    check("t6_tile_y", tile_y_base, 0);
    repeat (5) @(negedge clk);
    check("t6_no_cal", n_cals - c0, 0);
    s0 = n_starts;
    issue_cmd(4, 4, 4);
    serve(1, 0);
    wait_cal();
    check("t6_restart_starts", n_starts - s0, 1);
    check("t6_restart_latency", cal_cyc - done_cyc, 2);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
